// File: rtl/sc_test_pkg.sv
// Shared types and the default test table for the single-cycle processor run controller.
package sc_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_SETTLE,
        ST_CHECK,
        ST_NEXT,
        ST_DONE,
        ST_TIMEOUT
    } seq_state_t;

    typedef struct packed {
        logic [63:0] startpc;
        logic [63:0] endpc;
        logic [63:0] expected;
        logic        reset_before;
    } test_entry_t;

    localparam test_entry_t DEFAULT_ENTRY_0 = '{
        startpc:      64'h0,
        endpc:        64'h34,
        expected:     64'hF,
        reset_before: 1'b1
    };

    localparam test_entry_t DEFAULT_ENTRY_1 = '{
        startpc:      64'h0,
        endpc:        64'h54,
        expected:     64'h1234_5678_9ABC_DEF0,
        reset_before: 1'b0
    };

    // Unused slots finish immediately (endpc 0) and expect a zero result.
    localparam test_entry_t EMPTY_ENTRY = '0;

endpackage

// File: rtl/sc_test_table.sv
// Combinational ROM holding the test programs the sequencer walks through.
module sc_test_table
    import sc_test_pkg::*;
(
    input  logic [3:0]  index,
    output test_entry_t entry
);

    // Look up the entry for the requested test index.
    always_comb begin
        entry = EMPTY_ENTRY;
        case (index)
            4'd0:    entry = DEFAULT_ENTRY_0;
            4'd1:    entry = DEFAULT_ENTRY_1;
            default: entry = EMPTY_ENTRY;
        endcase
    end

endmodule

// File: rtl/sc_test_sequencer.sv
// Run controller: resets/starts the processor per table entry, waits for the
// terminal PC, checks the pass code, tallies results and guards with a watchdog.
module sc_test_sequencer
    import sc_test_pkg::*;
#(
    parameter int          TEST_COUNT   = 2,
    parameter logic [15:0] WATCHDOG_MAX = 16'h00FF,
    parameter int          RESET_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic [63:0] currentpc,
    input  logic [63:0] dmemout,
    output logic        proc_resetl,
    output logic [63:0] proc_startpc,
    output logic        busy,
    output logic        done,
    output logic [3:0]  test_num,
    output logic        test_pass,
    output logic        test_fail,
    output logic [7:0]  passed_count,
    output logic        all_passed,
    output logic        watchdog_expired
);

    localparam logic [3:0]  LAST_TEST   = 4'(TEST_COUNT - 1);
    localparam logic [7:0]  PASS_TARGET = 8'(TEST_COUNT);
    localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);

    seq_state_t  state;
    logic [15:0] wd_count;
    logic [15:0] rst_count;
    logic [3:0]  lookup_num;
    test_entry_t entry;

    // NEXT needs the upcoming entry; a fresh start always begins at entry 0.
    always_comb begin
        lookup_num = test_num;
        if (state == ST_NEXT) begin
            lookup_num = test_num + 4'd1;
        end else if (state == ST_IDLE || state == ST_DONE || state == ST_TIMEOUT) begin
            lookup_num = 4'd0;
        end
    end

    sc_test_table u_table (
        .index (lookup_num),
        .entry (entry)
    );

    assign all_passed = done && !watchdog_expired && (passed_count == PASS_TARGET);

    // Sequencer state machine with all outputs registered alongside the state.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state            <= ST_IDLE;
            proc_resetl      <= 1'b0;
            proc_startpc     <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            test_num         <= '0;
            test_pass        <= 1'b0;
            test_fail        <= 1'b0;
            passed_count     <= '0;
            watchdog_expired <= 1'b0;
            wd_count         <= '0;
            rst_count        <= '0;
        end else begin
            test_pass <= 1'b0;
            test_fail <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start) begin
                        passed_count     <= '0;
                        wd_count         <= '0;
                        watchdog_expired <= 1'b0;
                        test_num         <= '0;
                        rst_count        <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        if (entry.reset_before) begin
                            proc_startpc <= entry.startpc;
                            proc_resetl  <= 1'b0;
                            state        <= ST_RST;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RST, ST_RUN, ST_SETTLE: begin
                    if (wd_count == WATCHDOG_MAX) begin
                        state            <= ST_TIMEOUT;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        watchdog_expired <= 1'b1;
                        proc_resetl      <= 1'b0;
                    end else begin
                        wd_count <= wd_count + 16'd1;
                        if (state == ST_RST) begin
                            if (rst_count == RST_LAST) begin
                                proc_resetl <= 1'b1;
                                state       <= ST_RUN;
                            end else begin
                                rst_count <= rst_count + 16'd1;
                            end
                        end else if (state == ST_RUN) begin
                            if (currentpc >= entry.endpc) begin
                                state <= ST_SETTLE;
                            end
                        end else begin
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (dmemout == entry.expected) begin
                        test_pass <= 1'b1;
                        if (passed_count != 8'hFF) begin
                            passed_count <= passed_count + 8'd1;
                        end
                    end else begin
                        test_fail <= 1'b1;
                    end
                    state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (test_num == LAST_TEST) begin
                        state       <= ST_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        proc_resetl <= 1'b0;
                    end else begin
                        test_num  <= test_num + 4'd1;
                        rst_count <= '0;
                        if (entry.reset_before) begin
                            proc_startpc <= entry.startpc;
                            proc_resetl  <= 1'b0;
                            state        <= ST_RST;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_test_sequencer.sv
// Directed bench for sc_test_sequencer using a behavioural processor stub.
module tb_sc_test_sequencer;

    localparam logic [63:0] END0  = 64'h34;
    localparam logic [63:0] END1  = 64'h54;
    localparam logic [63:0] CODE0 = 64'hF;
    localparam logic [63:0] CODE1 = 64'h1234_5678_9ABC_DEF0;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        resetl = 1'b0;
    logic        start  = 1'b0;
    logic        start3 = 1'b0;
    logic [63:0] currentpc  = '0;
    logic [63:0] currentpc3 = '0;
    logic [63:0] dmemout, dmemout3;

    logic        proc_resetl, busy, done, test_pass, test_fail, all_passed, watchdog_expired;
    logic [63:0] proc_startpc;
    logic [3:0]  test_num;
    logic [7:0]  passed_count;

    logic        proc_resetl3, busy3, done3, test_pass3, test_fail3, all_passed3, watchdog_expired3;
    logic [63:0] proc_startpc3;
    logic [3:0]  test_num3;
    logic [7:0]  passed_count3;

    logic        stuck_mode = 1'b0;
    logic        skip_mode  = 1'b0;
    logic [63:0] dm_val [2];

    int tests_run    = 0;
    int tests_failed = 0;

    int obs_pass, obs_fail, obs_fail_num, obs_busy, obs_low0, obs_low1, obs_lat0, obs_lat1, obs_done;

    sc_test_sequencer dut (
        .CLK              (CLK),
        .resetl           (resetl),
        .start            (start),
        .currentpc        (currentpc),
        .dmemout          (dmemout),
        .proc_resetl      (proc_resetl),
        .proc_startpc     (proc_startpc),
        .busy             (busy),
        .done             (done),
        .test_num         (test_num),
        .test_pass        (test_pass),
        .test_fail        (test_fail),
        .passed_count     (passed_count),
        .all_passed       (all_passed),
        .watchdog_expired (watchdog_expired)
    );

    sc_test_sequencer #(.RESET_CYCLES(3)) dut3 (
        .CLK              (CLK),
        .resetl           (resetl),
        .start            (start3),
        .currentpc        (currentpc3),
        .dmemout          (dmemout3),
        .proc_resetl      (proc_resetl3),
        .proc_startpc     (proc_startpc3),
        .busy             (busy3),
        .done             (done3),
        .test_num         (test_num3),
        .test_pass        (test_pass3),
        .test_fail        (test_fail3),
        .passed_count     (passed_count3),
        .all_passed       (all_passed3),
        .watchdog_expired (watchdog_expired3)
    );

    // Processor stub: PC loads startpc in reset, otherwise steps by 4 (with stuck/skip variants).
    always @(posedge CLK) begin
        if (!proc_resetl) currentpc <= proc_startpc;
        else if (stuck_mode && currentpc == 64'h10) currentpc <= currentpc;
        else if (skip_mode && currentpc == 64'h30) currentpc <= 64'h38;
        else currentpc <= currentpc + 64'd4;
    end

    // Plain stub for the long-reset instance.
    always @(posedge CLK) begin
        if (!proc_resetl3) currentpc3 <= proc_startpc3;
        else currentpc3 <= currentpc3 + 64'd4;
    end

    assign dmemout  = (test_num <= 4'd1) ? dm_val[test_num[0]] : 64'h0;
    assign dmemout3 = (test_num3 == 4'd0) ? CODE0 : CODE1;

    typedef struct {
        string       name;
        logic [63:0] dm0;
        logic [63:0] dm1;
        bit          stuck;
        bit          skip;
        bit          noisy;
        int          exp_pass;
        int          exp_fail;
        int          exp_fail_num;
        int          exp_count;
        int          exp_all;
        int          exp_wd;
        int          exp_busy;
        int          exp_low0;
        int          exp_low1;
        int          exp_lat0;
        int          exp_lat1;
    } vec_t;

    function automatic vec_t makeVec(input string name, input logic [63:0] dm0, input logic [63:0] dm1,
                                     input bit stuck, input bit skip, input bit noisy,
                                     input int p, input int f, input int fnum, input int cnt, input int all,
                                     input int wd, input int bsy, input int l0, input int l1,
                                     input int lat0, input int lat1);
        vec_t v;
        v.name = name; v.dm0 = dm0; v.dm1 = dm1;
        v.stuck = stuck; v.skip = skip; v.noisy = noisy;
        v.exp_pass = p; v.exp_fail = f; v.exp_fail_num = fnum; v.exp_count = cnt; v.exp_all = all;
        v.exp_wd = wd; v.exp_busy = bsy; v.exp_low0 = l0; v.exp_low1 = l1;
        v.exp_lat0 = lat0; v.exp_lat1 = lat1;
        return v;
    endfunction

    task automatic checkOutput(input string what, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int reach0, reach1, pulse0, pulse1;
        stuck_mode = v.stuck;
        skip_mode  = v.skip;
        dm_val[0]  = v.dm0;
        dm_val[1]  = v.dm1;
        obs_pass = 0; obs_fail = 0; obs_fail_num = -1; obs_busy = 0;
        obs_low0 = 0; obs_low1 = 0; obs_done = 0;
        reach0 = -1; reach1 = -1; pulse0 = -1; pulse1 = -1;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done) begin
                obs_done = 1;
                break;
            end
            if (busy) obs_busy++;
            if (busy && !proc_resetl) begin
                if (test_num == 4'd0) obs_low0++;
                else obs_low1++;
            end
            if (busy && proc_resetl && test_num == 4'd0 && currentpc >= END0 && reach0 < 0) reach0 = i;
            if (busy && proc_resetl && test_num == 4'd1 && currentpc >= END1 && reach1 < 0) reach1 = i;
            if (test_pass) obs_pass++;
            if (test_fail) begin
                obs_fail++;
                if (obs_fail_num < 0) obs_fail_num = int'(test_num);
            end
            if ((test_pass || test_fail) && test_num == 4'd0 && pulse0 < 0) pulse0 = i;
            if ((test_pass || test_fail) && test_num == 4'd1 && pulse1 < 0) pulse1 = i;
            start = v.noisy && busy && (i % 3 == 1);
            @(negedge CLK);
        end
        start = 1'b0;
        obs_lat0 = (reach0 >= 0 && pulse0 >= 0) ? pulse0 - reach0 : -1;
        obs_lat1 = (reach1 >= 0 && pulse1 >= 0) ? pulse1 - reach1 : -1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".done"}, 64'(done), 64'd0);
        checkOutput({tag, ".proc_resetl"}, 64'(proc_resetl), 64'd0);
        checkOutput({tag, ".proc_startpc"}, proc_startpc, 64'd0);
        checkOutput({tag, ".test_num"}, 64'(test_num), 64'd0);
        checkOutput({tag, ".passed_count"}, 64'(passed_count), 64'd0);
        checkOutput({tag, ".wd_expired"}, 64'(watchdog_expired), 64'd0);
        checkOutput({tag, ".test_pass"}, 64'(test_pass), 64'd0);
        checkOutput({tag, ".test_fail"}, 64'(test_fail), 64'd0);
        checkOutput({tag, ".all_passed"}, 64'(all_passed), 64'd0);
    endtask

    vec_t vecs [6];

    initial begin
        int seen, low3, badpc3, busy3_cnt, fin3;

        vecs[0] = makeVec("nominal", CODE0, CODE1, 0, 0, 0, 2, 0, -1, 2, 1, 0, 26, 1, 0, 3, 3);
        vecs[1] = makeVec("fail0", 64'hE, CODE1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 26, 1, 0, 3, 3);
        vecs[2] = makeVec("stuck", CODE0, CODE1, 1, 0, 0, 0, 0, -1, 0, 0, 1, 256, 1, 0, -1, -1);
        vecs[3] = makeVec("skip", CODE0, CODE1, 0, 1, 0, 2, 0, -1, 2, 1, 0, 25, 1, 0, 3, 3);
        vecs[4] = makeVec("noisy", CODE0, CODE1, 0, 0, 1, 2, 0, -1, 2, 1, 0, 26, 1, 0, 3, 3);
        vecs[5] = makeVec("bitdiff", 64'h8000_0000_0000_000F, 64'h1234_5678_9ABC_DEF1,
                          0, 0, 0, 0, 2, 0, 0, 0, 0, 26, 1, 0, 3, 3);
        dm_val[0] = CODE0;
        dm_val[1] = CODE1;

        // Reset state
        resetl = 1'b0;
        repeat (3) @(negedge CLK);
        checkResetValues("reset");
        resetl = 1'b1;

        // Table-driven full runs
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k]);
            checkOutput({vecs[k].name, ".done_seen"}, 64'(obs_done), 64'd1);
            checkOutput({vecs[k].name, ".pass_pulses"}, 64'(obs_pass), 64'(vecs[k].exp_pass));
            checkOutput({vecs[k].name, ".fail_pulses"}, 64'(obs_fail), 64'(vecs[k].exp_fail));
            checkOutput({vecs[k].name, ".first_fail_num"}, 64'(obs_fail_num), 64'(vecs[k].exp_fail_num));
            checkOutput({vecs[k].name, ".passed_count"}, 64'(passed_count), 64'(vecs[k].exp_count));
            checkOutput({vecs[k].name, ".all_passed"}, 64'(all_passed), 64'(vecs[k].exp_all));
            checkOutput({vecs[k].name, ".wd_expired"}, 64'(watchdog_expired), 64'(vecs[k].exp_wd));
            checkOutput({vecs[k].name, ".busy_cycles"}, 64'(obs_busy), 64'(vecs[k].exp_busy));
            checkOutput({vecs[k].name, ".reset_low_t0"}, 64'(obs_low0), 64'(vecs[k].exp_low0));
            checkOutput({vecs[k].name, ".reset_low_t1"}, 64'(obs_low1), 64'(vecs[k].exp_low1));
            checkOutput({vecs[k].name, ".latency_t0"}, 64'(obs_lat0), 64'(vecs[k].exp_lat0));
            checkOutput({vecs[k].name, ".latency_t1"}, 64'(obs_lat1), 64'(vecs[k].exp_lat1));
            checkOutput({vecs[k].name, ".proc_resetl_end"}, 64'(proc_resetl), 64'd0);
        end

        // Start from DONE restarts with counts cleared
        stuck_mode = 1'b0; skip_mode = 1'b0;
        dm_val[0] = CODE0; dm_val[1] = CODE1;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        checkOutput("restart.passed_count", 64'(passed_count), 64'd0);
        checkOutput("restart.busy", 64'(busy), 64'd1);
        checkOutput("restart.done", 64'(done), 64'd0);
        checkOutput("restart.wd_expired", 64'(watchdog_expired), 64'd0);

        // Mid-run reset during test 1 aborts to reset values
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy && test_num == 4'd1) begin
                seen = 1;
                break;
            end
            @(negedge CLK);
        end
        checkOutput("midreset.reached_t1", 64'(seen), 64'd1);
        checkOutput("midreset.count_before", 64'(passed_count), 64'd1);
        resetl = 1'b0;
        @(negedge CLK);
        resetl = 1'b1;
        checkResetValues("midreset");
        repeat (4) @(negedge CLK);
        checkOutput("midreset.stays_idle", 64'(busy), 64'd0);
        checkOutput("midreset.no_done", 64'(done), 64'd0);

        // RESET_CYCLES=3 instance: three low cycles at startpc 0 before test 0
        low3 = 0; badpc3 = 0; busy3_cnt = 0; fin3 = 0;
        @(negedge CLK); start3 = 1'b1;
        @(negedge CLK); start3 = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (done3) begin
                fin3 = 1;
                break;
            end
            if (busy3) busy3_cnt++;
            if (busy3 && !proc_resetl3) begin
                low3++;
                if (proc_startpc3 != 64'h0) badpc3++;
            end
            @(negedge CLK);
        end
        checkOutput("rc3.done_seen", 64'(fin3), 64'd1);
        checkOutput("rc3.reset_low", 64'(low3), 64'd3);
        checkOutput("rc3.startpc_bad", 64'(badpc3), 64'd0);
        checkOutput("rc3.busy_cycles", 64'(busy3_cnt), 64'd28);
        checkOutput("rc3.passed_count", 64'(passed_count3), 64'd2);
        checkOutput("rc3.all_passed", 64'(all_passed3), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sc_test_sequencer.md
Name: sc_test_sequencer

Overview:
- Hardware run controller for the single-cycle processor (`singlecycle`); replaces the hand-written stimulus loop.
- Iterates a fixed table of test programs. Per test it optionally resets the processor at a given start PC, lets it run until `currentpc` reaches a terminal PC, waits one settle cycle, then compares `dmemout` against an expected pass code.
- Tallies passes, enforces a global watchdog and reports the final verdict.
- Sits between top-level run logic and the processor's `resetl`/`startpc`/`currentpc`/`dmemout` ports.

Parameters:
- TEST_COUNT, 2, number of table entries executed (1..16).
- WATCHDOG_MAX, 16'h00FF, total cycles allowed in RST/RUN/SETTLE across the whole run before abort.
- RESET_CYCLES, 1, cycles `proc_resetl` is held low for a test with `reset_before`=1 (>=1).

Ports:
- CLK, input, 1, system clock; all state updates on rising edge.
- resetl, input, 1, synchronous active-low reset.
- start, input, 1, one-cycle request to begin a run; honoured only in IDLE, DONE or TIMEOUT.
- currentpc, input, 64, processor current PC.
- dmemout, input, 64, processor data-memory read output.
- proc_resetl, output, 1, drives processor `resetl`; registered.
- proc_startpc, output, 64, drives processor `startpc`; registered.
- busy, output, 1, high in RST/RUN/SETTLE/CHECK/NEXT.
- done, output, 1, high in DONE or TIMEOUT.
- test_num, output, 4, index of the current or last test.
- test_pass, output, 1, one-cycle pulse: the test just checked matched.
- test_fail, output, 1, one-cycle pulse: the test just checked mismatched.
- passed_count, output, 8, number of passing tests in this run.
- all_passed, output, 1, `done` && !`watchdog_expired` && `passed_count`==TEST_COUNT.
- watchdog_expired, output, 1, sticky until next `start` or reset.

Behaviour:
- Clock port is `CLK`; reset port is `resetl`, synchronous, active-low.
- Reset values:
  - State IDLE.
  - `proc_resetl`=0 and `proc_startpc`=0.
  - `busy`, `done`, `test_pass`, `test_fail`, `watchdog_expired` = 0.
  - `test_num`, `passed_count`, watchdog counter = 0.
- Reset asserted mid-run aborts immediately to these values; a new `start` is required.
- States and transitions:
  - IDLE: processor held in reset. On `start`: clear counts and watchdog, `test_num`=0, go to NEXT-entry logic.
  - Test entry: if table[`test_num`].`reset_before`, load `proc_startpc`=entry.startpc and go to RST; else go to RUN with `proc_resetl` unchanged (processor keeps running).
  - RST: `proc_resetl`=0 for RESET_CYCLES cycles, then `proc_resetl`=1 and go to RUN.
  - RUN: each cycle, if `currentpc` >= entry.endpc (unsigned) go to SETTLE. Overshoot past endpc counts as reached.
  - SETTLE: exactly one cycle, so `dmemout` reflects the final load.
  - CHECK: compare `dmemout` to entry.expected over all 64 bits; register the result.
  - NEXT: `test_pass` or `test_fail` pulses this cycle; `passed_count` increments on pass.
    - If `test_num`==TEST_COUNT-1, go to DONE.
    - Else increment `test_num` and apply test entry.
  - DONE: `proc_resetl`=0 (processor frozen), `done`=1.
  - TIMEOUT: same as DONE plus `watchdog_expired`=1; no pass/fail pulse for the aborted test.
- Check timing: RUN condition true in cycle t → SETTLE t+1 → CHECK t+2 samples `dmemout` → pulse visible in t+3.
- Watchdog:
  - 16-bit counter increments in RST/RUN/SETTLE.
  - When it equals WATCHDOG_MAX while in any of those states, go to TIMEOUT next cycle, overriding every other transition.
  - Does not wrap.
- `start` outside IDLE/DONE/TIMEOUT is ignored. `start` in DONE/TIMEOUT restarts with all counts cleared.
- `passed_count` saturates at 255.

Decomposition:
- Package `sc_test_pkg`:
  - State enum.
  - Test-entry struct: `startpc`[63:0], `endpc`[63:0], `expected`[63:0], `reset_before`.
  - Default table constants.
- Default table:
  - Entry 0: startpc 0x0, endpc 0x34, expected 0xF, reset_before=1.
  - Entry 1: endpc 0x54, expected 0x123456789ABCDEF0, reset_before=0.
- Sub-module `sc_test_table`: combinational ROM indexed by `test_num`, returning the entry struct.

Test Plan:
- Behavioural processor stub: PC resets to `startpc`, +4 per cycle while `resetl`=1. Bench drives `dmemout`=0xF at test-0 CHECK and 0x123456789ABCDEF0 at test-1 CHECK.
  - Required: two `test_pass` pulses; `passed_count`=2; `all_passed`=1.
  - Required: `proc_resetl` low exactly 1 cycle before test 0 and never before test 1.
- Test-0 `dmemout`=0xE, test 1 correct → `test_fail` with `test_num`=0, then `test_pass`; final `passed_count`=1, `all_passed`=0, `done`=1.
- Stub PC stuck at 0x10 → TIMEOUT after 255 counted cycles; `watchdog_expired`=1, `proc_resetl`=0, no pass/fail pulse, `passed_count`=0.
- PC jumps 0x30→0x38 (skips 0x34) → SETTLE entered the cycle after 0x38 is seen; check proceeds normally.
- `resetl`=0 for one cycle during RUN of test 1 → all outputs at reset values next cycle; `start` pulses while `busy` are ignored; `start` in DONE restarts with `passed_count`=0.
- RESET_CYCLES=3 build → `proc_resetl` low exactly 3 cycles with `proc_startpc`=0 before test 0.
